// File: rtl/dp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dp_ctrl_pkg
// Shared definitions for the data-processing issue controller:
//   - issue FSM state encoding (IDLE/EXEC/WB)
//   - opcode indices of the attached per-opcode ALU op units
//   - bit positions of N/Z/C inside the packed flag register
// -----------------------------------------------------------------------------
package dp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Opcode index == bit position in op_en
    localparam int unsigned OP_AND = 0;
    localparam int unsigned OP_EOR = 1;
    localparam int unsigned OP_SUB = 2;
    localparam int unsigned OP_RSB = 3;
    localparam int unsigned OP_ADD = 4;
    localparam int unsigned OP_ADC = 5;
    localparam int unsigned OP_SBC = 6;
    localparam int unsigned OP_RSC = 7;
    localparam int unsigned OP_TST = 8;
    localparam int unsigned OP_TEQ = 9;
    localparam int unsigned OP_CMP = 10;
    localparam int unsigned OP_CMN = 11;
    localparam int unsigned OP_ORR = 12;
    localparam int unsigned OP_MOV = 13;
    localparam int unsigned OP_BIC = 14;
    localparam int unsigned OP_MVN = 15;

    // Packed flag register layout
    localparam int unsigned FLG_C = 0;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_W = 3;

endpackage

// File: rtl/dp_op_decode.sv
// -----------------------------------------------------------------------------
// dp_op_decode
// Combinational opcode decoder: opcode index -> one-hot op-unit enable plus a
// legal bit (opcode addresses an attached unit).
// Ports:
//   op_i      in  OP_W   opcode index
//   onehot_o  out N_OPS  one-hot enable (all zero for an illegal opcode)
//   legal_o   out 1      op_i < N_OPS
// -----------------------------------------------------------------------------
module dp_op_decode
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned N_OPS = 16,
    parameter int unsigned OP_W  = 4
) (
    input  logic [OP_W-1:0]  op_i,
    output logic [N_OPS-1:0] onehot_o,
    output logic             legal_o
);

    // Equality per unit rather than a range compare: stays meaningful (and
    // free of constant-compare results) when N_OPS == 2**OP_W.
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < N_OPS; i++) begin
            if (op_i == OP_W'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

    assign legal_o = |onehot_o;

endmodule

// File: rtl/dp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// dp_issue_ctrl
// Sequences decoded data-processing instructions onto the per-opcode ALU op
// units. One request is accepted via valid/ready; exactly one unit is enabled
// for LAT cycles, then its result and flags are captured. Owns the
// architectural N/Z/C register and hands Rd to register-file writeback.
//
// Configuration macro: DP_ILLEGAL_TRAP_EN
//   defined   : illegal opcode (>= N_OPS) is accepted, dropped, err pulses
//               for the cycle after accept.
//   undefined : illegal opcode is accepted as a NOP, err tied 0.
//
// Ports:
//   clk, rst              clock (posedge), async active-high reset
//   req_valid/req_ready   request handshake
//   req_op/s/wb/rd        opcode, commit-flags, write-Rd, destination
//   op_en                 one-hot enable to op units (EXEC only)
//   flag_n/z/c            architectural flags (also unit carry/neg/zero in)
//   res_in, n_in/z_in/c_in result and flags from the enabled unit
//   wb_valid/wb_ready     writeback handshake; wb_rd/wb_data payload
//   busy                  state != IDLE
//   err                   illegal-opcode pulse
// -----------------------------------------------------------------------------
module dp_issue_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned N_OPS = 16,
    parameter int unsigned OP_W  = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic             req_s,
    input  logic             req_wb,
    input  logic [3:0]       req_rd,
    output logic [N_OPS-1:0] op_en,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    input  logic [31:0]      res_in,
    input  logic             n_in,
    input  logic             z_in,
    input  logic             c_in,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [3:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(LAT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_OPS-1:0]   en_q, en_d;
    logic               s_q, s_d;
    logic               wb_q, wb_d;
    logic [3:0]         rd_q, rd_d;
    logic [FLG_W-1:0]   flags_q, flags_d;
    logic [3:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;

    logic [N_OPS-1:0]   dec_onehot;
    logic               dec_legal;
    logic               accept;

    dp_op_decode #(
        .N_OPS (N_OPS),
        .OP_W  (OP_W)
    ) u_dec (
        .op_i     (req_op),
        .onehot_o (dec_onehot),
        .legal_o  (dec_legal)
    );

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Opcode is decoded at accept and held one-hot; equivalent to 1<<op_q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        s_d       = s_q;
        wb_d      = wb_q;
        rd_d      = rd_q;
        flags_d   = flags_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    s_d   = req_s;
                    wb_d  = req_wb;
                    rd_d  = req_rd;
                    en_d  = dec_onehot;
                    cnt_d = CNT_W'(LAT - 1);
                    if (dec_legal) begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    wb_data_d = res_in;
                    wb_rd_d   = rd_q;
                    if (s_q) begin
                        flags_d[FLG_N] = n_in;
                        flags_d[FLG_Z] = z_in;
                        flags_d[FLG_C] = c_in;
                    end
                    state_d = wb_q ? ST_WB : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            en_q      <= '0;
            s_q       <= 1'b0;
            wb_q      <= 1'b0;
            rd_q      <= '0;
            flags_q   <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            s_q       <= s_d;
            wb_q      <= wb_d;
            rd_q      <= rd_d;
            flags_q   <= flags_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

`ifdef DP_ILLEGAL_TRAP_EN
    logic err_q, err_d;

    assign err_d = accept && !dec_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Gated by state so an async reset mid-op drops the enable immediately.
    assign op_en    = (state_q == ST_EXEC) ? en_q : '0;
    assign flag_n   = flags_q[FLG_N];
    assign flag_z   = flags_q[FLG_Z];
    assign flag_c   = flags_q[FLG_C];
    assign wb_valid = (state_q == ST_WB);
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
